// File: rtl/inst_fetch_pkg.sv
// Shared pipeline package: opcode constants, NOP word, fetch FSM encoding.
// Imported by fetch and decode so both sides agree on encodings.
package inst_fetch_pkg;

  localparam logic [6:0] OP_JAL       = 7'b1101111;
  localparam logic [6:0] OP_JALR      = 7'b1100111;
  localparam logic [6:0] OP_BRANCH    = 7'b1100011;
  localparam logic [6:0] OP_LOAD      = 7'b0000011;
  localparam logic [6:0] OP_STORE     = 7'b0100011;
  localparam logic [6:0] OP_LUI       = 7'b0110111;
  localparam logic [6:0] OP_AUIPC     = 7'b0010111;
  localparam logic [6:0] OP_ARITH_I   = 7'b0010011;
  localparam logic [6:0] OP_ARITH_R   = 7'b0110011;
  localparam logic [6:0] OP_ARITH_IW  = 7'b0011011;
  localparam logic [6:0] OP_ARITH_RW  = 7'b0111011;

  localparam logic [31:0] NOP_INST = 32'h00000013;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_DROP  = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] word;
  } skid_t;

endpackage

// File: rtl/inst_fetch_jal_target_gen.sv
// JAL target generator: decodes the J-immediate and adds it to pc.
// Ports: inst (32b word), pc (64b) -> target (64b), is_jal.
module jal_target_gen
  import inst_fetch_pkg::*;
(
  input  logic [31:0] inst,
  input  logic [63:0] pc,
  output logic [63:0] target,
  output logic        is_jal
);

  logic [20:0] imm;
  logic        unused_rd;

  assign imm = {inst[31], inst[19:12], inst[20],
                inst[30:21], 1'b0};

  assign is_jal = (inst[6:0] == OP_JAL);
  assign target = pc + {{43{imm[20]}}, imm};

  // rd field is decode's business
  assign unused_rd = ^inst[11:7];

endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: holds pc, single-outstanding imem requests, skid buffer
// for decode stalls, local JAL resolution, redirect flush to NOP.
// Ports: CLK, reset (sync, high); stall, redirect_en/redirect_pc from
// downstream; imem_req/imem_addr/imem_ready/imem_rdata to memory;
// inst/PC_o/inst_valid to decode.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_0001_0000
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_en,
  input  logic [63:0] redirect_pc,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [63:0] PC_o,
  output logic        inst_valid
);

  fetch_state_t state_q, state_d;

  logic [63:0] pc_q;
  logic [63:0] drop_addr_q;
  logic [63:0] tgt_pc;
  logic [63:0] pc_seq;
  logic [63:0] jal_tgt;
  logic [63:0] pc_next;
  skid_t       skid_q;
  logic [31:0] fetch_word;
  logic        is_jal;
  logic        present;
  logic        capture;
  logic        bubble;
  logic        enter_drop;

  assign tgt_pc = redirect_pc & ~64'd1;

  always_ff @(posedge CLK) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: begin
        if (redirect_en)
          state_d = imem_ready ? S_FETCH : S_DROP;
        else if (imem_ready && stall)
          state_d = S_HOLD;
      end
      S_HOLD: begin
        if (redirect_en || !stall)
          state_d = S_FETCH;
      end
      S_DROP: begin
        // a redirect without ready just retargets pc
        if (imem_ready)
          state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    imem_req   = 1'b0;
    imem_addr  = pc_q;
    fetch_word = imem_rdata;
    present    = 1'b0;
    capture    = 1'b0;
    enter_drop = 1'b0;
    unique case (state_q)
      S_IDLE: ;
      S_FETCH: begin
        imem_req   = 1'b1;
        present    = imem_ready & ~stall & ~redirect_en;
        capture    = imem_ready & stall & ~redirect_en;
        enter_drop = redirect_en & ~imem_ready;
      end
      S_HOLD: begin
        fetch_word = skid_q.word;
        present    = ~stall & ~redirect_en & skid_q.valid;
      end
      S_DROP: begin
        // keep the stale request stable until memory answers
        imem_req  = 1'b1;
        imem_addr = drop_addr_q;
      end
      default: ;
    endcase
    bubble = redirect_en | (~present & ~stall);
  end

  jal_target_gen u_jal (
    .inst   (fetch_word),
    .pc     (pc_q),
    .target (jal_tgt),
    .is_jal (is_jal)
  );

  assign pc_seq  = pc_q + 64'd4;
  assign pc_next = is_jal ? jal_tgt : pc_seq;

  always_ff @(posedge CLK) begin
    if (reset) begin
      pc_q        <= RESET_PC;
      drop_addr_q <= RESET_PC;
      skid_q      <= '0;
      inst        <= NOP_INST;
      PC_o        <= '0;
      inst_valid  <= 1'b0;
    end else begin
      if (redirect_en)  pc_q <= tgt_pc;
      else if (present) pc_q <= pc_next;

      if (enter_drop) drop_addr_q <= pc_q;

      if (redirect_en)  skid_q <= '0;
      else if (capture) skid_q <= '{valid: 1'b1, word: imem_rdata};
      else if (present) skid_q <= '0;

      if (present) begin
        inst       <= fetch_word;
        PC_o       <= pc_q;
        inst_valid <= 1'b1;
      end else if (bubble) begin
        inst       <= NOP_INST;
        inst_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios plus a random
// phase checked against an architectural pc-stream model.
module tb_inst_fetch;

  localparam logic [63:0] RST_PC = 64'h10000;
  localparam logic [31:0] NOP    = 32'h00000013;

  logic        CLK = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_en;
  logic [63:0] redirect_pc;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic [63:0] PC_o;
  logic        inst_valid;

  inst_fetch #(.RESET_PC(RST_PC)) dut (
    .CLK         (CLK),
    .reset       (reset),
    .stall       (stall),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .inst        (inst),
    .PC_o        (PC_o),
    .inst_valid  (inst_valid)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;
  int gap     = 0;
  int deliveries = 0;
  int wait_left  = 0;
  bit auto_mem = 0;
  bit jal_en   = 0;
  logic [63:0] exp_pc = RST_PC;
  logic [31:0] prog [logic [63:0]];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] jal_word(input logic [20:0] off);
    return {off[20], off[10:1], off[11], off[19:12], 5'd1, 7'b1101111};
  endfunction

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    logic [31:0] h;
    int o;
    if (prog.exists(a)) return prog[a];
    h = a[33:2] * 32'h9E3779B1;
    if (jal_en && h[31:29] == 3'd5) begin
      o = int'(h[8:4]) - 8;
      if (o == 0) o = 5;
      return jal_word(21'(o * 4));
    end
    return {a[13:2], 5'd1, 3'b000, 5'd1, 7'b0010011};
  endfunction

  // architectural successor of a delivered instruction
  function automatic logic [63:0] next_pc(input logic [63:0] pc,
                                          input logic [31:0] w);
    longint off;
    if (w[6:0] == 7'b1101111) begin
      off = longint'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
      return pc + 64'(off);
    end
    return pc + 64'd4;
  endfunction

  task automatic cyc();
    logic [31:0] p_inst;
    logic [63:0] p_pco, p_addr, e_rpc;
    logic        p_val, p_req, e_rst, e_stall, e_redir, e_ready;
    logic [31:0] w;
    if (auto_mem) begin
      if (imem_req) begin
        if (wait_left == 0) begin
          imem_ready = 1'b1;
          wait_left  = $urandom_range(0, 2);
        end else begin
          imem_ready = 1'b0;
          wait_left--;
        end
      end else imem_ready = 1'b0;
    end
    imem_rdata = mem_word(imem_addr);
    p_inst = inst; p_pco = PC_o; p_val = inst_valid;
    p_req = imem_req; p_addr = imem_addr;
    e_rst = reset; e_stall = stall; e_redir = redirect_en;
    e_rpc = redirect_pc; e_ready = imem_ready;
    @(posedge CLK);
    #1;
    if (e_rst) begin
      chk("rst_inst", 64'(inst), 64'(NOP));
      chk("rst_pco", PC_o, 64'd0);
      chk("rst_valid", 64'(inst_valid), 64'd0);
      chk("rst_req", 64'(imem_req), 64'd0);
      chk("rst_addr", imem_addr, RST_PC);
      exp_pc = RST_PC;
      gap = 0;
    end else begin
      if (p_req && !e_ready) begin
        chk("req_held", 64'(imem_req), 64'd1);
        chk("addr_held", imem_addr, p_addr);
      end
      if (e_redir) begin
        chk("redir_inst", 64'(inst), 64'(NOP));
        chk("redir_valid", 64'(inst_valid), 64'd0);
        chk("redir_pco", PC_o, p_pco);
        exp_pc = e_rpc & ~64'd1;
        gap = 0;
      end else if (e_stall) begin
        chk("stall_inst", 64'(inst), 64'(p_inst));
        chk("stall_pco", PC_o, p_pco);
        chk("stall_valid", 64'(inst_valid), 64'(p_val));
      end else if (inst_valid) begin
        w = mem_word(exp_pc);
        chk("dlv_pc", PC_o, exp_pc);
        chk("dlv_inst", 64'(inst), 64'(w));
        exp_pc = next_pc(exp_pc, w);
        deliveries++;
        gap = 0;
      end else begin
        chk("bub_inst", 64'(inst), 64'(NOP));
        chk("bub_pco", PC_o, p_pco);
        gap++;
        if (gap > 12) begin
          chk("progress_gap", 64'(gap), 64'd12);
          gap = 0;
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect_en = 1'b0;
    redirect_pc = '0; imem_ready = 1'b1; imem_rdata = '0;
    cyc(); cyc();
    // late ready while IDLE is ignored
    reset = 1'b0;
    cyc();
    chk("idle_ready_ign", 64'(inst_valid), 64'd0);
    chk("first_req", 64'(imem_req), 64'd1);
    chk("first_addr", imem_addr, 64'h10000);
    // zero-wait stream
    cyc();
    chk("zw_valid0", 64'(inst_valid), 64'd1);
    chk("zw_addr1", imem_addr, 64'h10004);
    cyc();
    chk("zw_valid1", 64'(inst_valid), 64'd1);
    chk("zw_addr2", imem_addr, 64'h10008);
    // ready at 0x10008 with stall for 3 cycles
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      imem_ready = 1'b0;
      chk("hold_req", 64'(imem_req), 64'd0);
      chk("hold_pco", PC_o, 64'h10004);
    end
    stall = 1'b0;
    cyc();
    chk("rel_inst", 64'(inst), 64'(mem_word(64'h10008)));
    chk("rel_pco", PC_o, 64'h10008);
    chk("rel_addr", imem_addr, 64'h1000C);
    chk("rel_req", 64'(imem_req), 64'd1);
    // redirect in the first of 3 wait cycles
    redirect_en = 1'b1; redirect_pc = 64'h20001;
    cyc();
    redirect_en = 1'b0;
    chk("drop_addr0", imem_addr, 64'h1000C);
    cyc();
    chk("drop_addr1", imem_addr, 64'h1000C);
    cyc();
    chk("drop_addr2", imem_addr, 64'h1000C);
    imem_ready = 1'b1;
    cyc();
    chk("drop_valid", 64'(inst_valid), 64'd0);
    chk("drop_inst", 64'(inst), 64'(NOP));
    chk("drop_new", imem_addr, 64'h20000);
    cyc();
    chk("tgt_pco", PC_o, 64'h20000);
    // redirect + ready while stalled
    stall = 1'b1; redirect_en = 1'b1; redirect_pc = 64'h30000;
    cyc();
    stall = 1'b0; redirect_en = 1'b0;
    chk("rr_valid", 64'(inst_valid), 64'd0);
    chk("rr_addr", imem_addr, 64'h30000);
    cyc();
    chk("rr_pco", PC_o, 64'h30000);
    // reset while in DROP
    imem_ready = 1'b0; redirect_en = 1'b1; redirect_pc = 64'h40000;
    cyc();
    redirect_en = 1'b0;
    chk("in_drop_addr", imem_addr, 64'h30004);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    prog[64'h10004] = jal_word(21'h100);
    cyc();
    chk("restart_addr", imem_addr, 64'h10000);
    imem_ready = 1'b1;
    cyc();
    cyc();
    chk("jal_inst", 64'(inst), 64'(jal_word(21'h100)));
    chk("jal_pco", PC_o, 64'h10004);
    chk("jal_next", imem_addr, 64'h10104);
    cyc();
    chk("jal_tgt_pco", PC_o, 64'h10104);
    // random phase
    jal_en = 1; auto_mem = 1; deliveries = 0;
    reset = 1'b1;
    cyc();
    for (int i = 0; i < 3000; i++) begin
      reset       = ($urandom_range(0, 399) == 0);
      stall       = ($urandom_range(0, 3) == 0);
      redirect_en = ($urandom_range(0, 15) == 0);
      redirect_pc = 64'h40000 + 64'($urandom_range(0, 4095)) * 4
                    + 64'($urandom_range(0, 3));
      cyc();
    end
    chk("deliveries", 64'(deliveries > 400), 64'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Front-end fetch stage of the RV64 pipeline and the producer side of the decoder's `inst`/`PC_i` interface. It holds the program counter and issues single-outstanding requests to instruction memory. It delivers one registered instruction plus PC to decode per cycle, honours decode's `stall`, and resolves JAL locally. Taken branches and JALR arrive as a redirect from downstream, which flushes in-flight fetches and substitutes NOPs.

## Interface
Parameters:
- RESET_PC, 64'h0000_0000_0001_0000, first fetch address after reset.

Ports:
- CLK  in  1  clock; all state on posedge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  decode hold request; `inst`/`PC_o`/`inst_valid` must stay unchanged while high.
- redirect_en  in  1  taken branch or JALR resolved downstream.
- redirect_pc  in  64  new fetch target; bit 0 is ignored and forced to 0.
- imem_req  out  1  request valid; held with a stable `imem_addr` until `imem_ready`.
- imem_addr  out  64  fetch address.
- imem_ready  in  1  response for the outstanding request this cycle.
- imem_rdata  in  32  instruction word; valid when `imem_ready`.
- inst  out  32  instruction to decode.
- PC_o  out  64  address of `inst`.
- inst_valid  out  1  `inst` is a real fetched instruction, not a bubble.

## Operation
- **States:**
  - IDLE: post-reset, no request.
  - FETCH: `imem_req`=1, `imem_addr`=pc.
  - HOLD: a response is buffered while `stall` is high; `imem_req`=0.
  - DROP: a stale request is outstanding; `imem_req`=1 at the saved address; the response is discarded.
- **Transitions:**
  - IDLE→FETCH unconditionally.
  - FETCH, ready, no redirect, stall=0: present the instruction, advance pc, stay in FETCH.
  - FETCH, ready, stall=1: capture into the skid buffer and go to HOLD; pc is not yet advanced.
  - FETCH, !ready, redirect: pc←redirect_pc, go to DROP.
  - DROP, ready: discard, go to FETCH.
  - HOLD, stall falls: present the buffer, advance pc, go to FETCH.
- **Next pc:**
  - If the fetched opcode is 7'b1101111 (JAL): pc + sext({rdata[31],rdata[19:12],rdata[20],rdata[30:21],1'b0}), in 64-bit wraparound arithmetic.
  - Otherwise pc+4.
  - The JAL word is still delivered to decode, which needs it for the rd=PC+4 write.
- **Redirect:**
  - Redirect has priority over stall and over the response.
  - In any state, a redirect sets inst←32'h00000013, inst_valid←0 and clears the skid buffer.
  - A response arriving in the same cycle as the redirect is discarded and the next state is FETCH at redirect_pc.
  - A redirect while in DROP overwrites the pending target and stays in DROP.
- **Bubble:** any cycle with no presented instruction and stall=0 drives inst=32'h00000013, inst_valid=0, and leaves PC_o unchanged.

## Timing
- **Reset values:**
  - state IDLE, pc=RESET_PC, `imem_req`=0, `imem_addr`=RESET_PC.
  - `inst`=32'h00000013, `PC_o`=0, `inst_valid`=0, skid buffer empty.
- **First request:** `imem_req` rises on the second cycle after reset deasserts.
- **Latency:** `imem_ready` at edge t with stall=0 puts `inst`/`PC_o` at t+1, with the next `imem_addr` also at t+1. A zero-wait memory sustains 1 instruction per cycle.
- **Stall release:** after stall falls, the buffered instruction appears on the next edge and the next request issues in that same cycle.
- **Redirect latency:** the first instruction from redirect_pc appears no earlier than 2 edges after redirect_en. Add the extra wait cycles when in DROP.
- **Reset mid-operation:** an outstanding request is abandoned. Memory must tolerate this: a late `imem_ready` while in IDLE is ignored.

## Structure
- The shared pipeline package holds:
  - the opcode constants (JAL, JALR, BRANCH, LOAD, STORE, LUI, AUIPC, ARITHMETIC*) shared with decode;
  - NOP_INST = 32'h00000013;
  - the 2-bit state encoding.
- One sub-module is natural: `jal_target_gen`, a combinational unit taking the instruction and pc and returning the JAL target and an is_jal flag.

## Test plan
- Reset, zero-wait memory returning addi words → `imem_addr` 0x10000, 0x10004, 0x10008 on consecutive cycles; `inst_valid` stays high from the cycle after the first ready.
- A JAL with imm=+0x100 fetched at 0x10004 → JAL presented with PC_o=0x10004; the next `imem_addr` is 0x10104.
- Ready at 0x10008 with stall=1 for 3 cycles → `inst`/`PC_o` stay frozen and `imem_req`=0 during HOLD. One cycle after stall falls, `inst` shows the 0x10008 word; the next address is 0x1000C.
- A 3-cycle wait state with redirect_pc=0x20001 in its first cycle → `imem_addr` stays at the old address until ready. That response is dropped, then `imem_addr`=0x20000, and `inst`=0x00000013 with inst_valid=0 in between.
- Redirect and ready in the same cycle while stall=1 → the response is discarded, the bubble is presented, and the next `imem_addr` is redirect_pc.
- reset asserted while in DROP → all outputs return to their reset values on the next edge; fetch restarts at 0x10000.
